// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed, double-buffered hex driver for a common-anode 7-seg display
//   Ports: clk, rst_n (async active-low), value[4*NUM_DIGITS] (nibble i -> digit i),
//          digit_en[NUM_DIGITS] (1 = lit), load (capture strobe),
//          anode[NUM_DIGITS] (one-hot active-low, registered), segs[7] ({G..A} active-low, registered),
//          frame_done (pulse on the last cycle of the last digit's slot).
//   Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits, digit 0 always shown).
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD_CYC   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              segs,
    output logic                    frame_done
);
    localparam int DW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(REFRESH_DIV - 2);
    localparam logic [DW-1:0] GUARD    = DW'(GUARD_CYC);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [DW-1:0]           div;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] stage_val, shadow_val, nxt_val;
    logic [NUM_DIGITS-1:0]   stage_en, shadow_en, nxt_en, nxt_vis;
    logic                    pending, last_div, boundary, blank;
    logic [3:0]              nib;
    assign last_div = div == DIV_LAST;
    assign boundary = last_div && idx == IDX_LAST;
    // A load coinciding with the frame boundary bypasses staging straight into the shadow.
    assign nxt_val  = load ? value : stage_val;
    assign nxt_en   = load ? digit_en : stage_en;
    assign nib      = shadow_val[{idx, 2'b00} +: 4];
    assign blank    = div < GUARD || !shadow_en[idx];
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    // Walk from the top digit down; a zero stays suppressed while everything above is zero or blanked.
    always_comb begin
        nxt_vis = nxt_en;
        lead    = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lead && nxt_val[4*i +: 4] == 4'h0) nxt_vis[i] = 1'b0;
            lead = lead && (nxt_val[4*i +: 4] == 4'h0 || !nxt_en[i]);
        end
    end
`else
    assign nxt_vis = nxt_en;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div        <= '0;
            idx        <= '0;
            anode      <= '1;
            segs       <= 7'h7F;
            frame_done <= 1'b0;
            stage_val  <= '0;
            stage_en   <= '0;
            shadow_val <= '0;
            shadow_en  <= '0;
            pending    <= 1'b0;
        end else begin
            div        <= last_div ? '0 : div + 1'b1;
            if (last_div) idx <= idx == IDX_LAST ? '0 : idx + 1'b1;
            anode      <= div < GUARD ? '1 : ~(NUM_DIGITS'(1) << idx);
            segs       <= blank ? 7'h7F : HEX[nib];
            // Registered one cycle early so the pulse lines up with the boundary cycle itself.
            frame_done <= div == DIV_PRE && idx == IDX_LAST;
            if (load) begin
                stage_val <= value;
                stage_en  <= digit_en;
            end
            if (boundary && (load || pending)) begin
                shadow_val <= nxt_val;
                shadow_en  <= nxt_vis;
            end
            pending    <= boundary ? 1'b0 : (pending | load);
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: table-driven, directed and randomized checks of seven_seg_scan_driver
module tb_seven_seg_scan_driver;
    localparam int N = 4, R = 8, G = 2, FR = N * R;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    typedef struct {
        logic [15:0]     v;
        logic [3:0]      e;
        logic [3:0][6:0] s;
    } vec_t;
    typedef struct {
        int          at;
        logic [15:0] v;
        logic [3:0]  e;
    } ld_t;
    logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0, frame_done;
    logic [15:0] value = '0;
    logic [3:0]  digit_en = '0, anode;
    logic [6:0]  segs;
    int          cyc = 0, n_vec = 0, n_err = 0;
    ld_t         q[$];
    vec_t        tbl[6];
    seven_seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYC(G)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .digit_en(digit_en), .load(load),
        .anode(anode), .segs(segs), .frame_done(frame_done));
    always #5 clk = ~clk;
    // Value shown in frame f: the last load sampled no later than that frame's opening boundary edge.
    function automatic logic [19:0] shown(int f);
        logic [19:0] r;
        r = '0;
        foreach (q[i]) if (q[i].at <= FR * f) r = {q[i].v, q[i].e};
        return r;
    endfunction
    function automatic logic [3:0] visible(logic [15:0] v, logic [3:0] e);
        logic [3:0] r;
        bit lead;
        r = e;
        for (int i = 1; i < N; i++) begin
            lead = 1'b1;
            for (int j = i + 1; j < N; j++) if (v[4*j +: 4] != 4'h0 && e[j]) lead = 1'b0;
            if (LZ && lead && v[4*i +: 4] == 4'h0) r[i] = 1'b0;
        end
        return r;
    endfunction
    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, exp);
        end
    endtask
    task automatic check_model();
        int t, f, s, off;
        logic [19:0] sh;
        logic [3:0] vis, ea;
        logic [6:0] es;
        logic ef;
        t = cyc - 1;
        f = t / FR;
        s = (t % FR) / R;
        off = t % R;
        sh = shown(f);
        vis = visible(sh[19:4], sh[3:0]);
        ea = off < G ? 4'hF : ~(4'b0001 << s);
        es = (off < G || !vis[s]) ? 7'h7F : HEX[sh[4 + 4*s +: 4]];
        ef = (cyc % FR) == FR - 1;
        n_vec++;
        if (anode !== ea || segs !== es || frame_done !== ef) begin
            n_err++;
            $display("FAIL model cyc=%0d anode %h want %h segs %h want %h frame_done %b want %b",
                     cyc, anode, ea, segs, es, frame_done, ef);
        end
    endtask
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] e);
        load = ld;
        value = v;
        digit_en = e;
        @(posedge clk);
        cyc++;
        if (ld) q.push_back('{cyc, v, e});
        @(negedge clk);
        load = 1'b0;
        check_model();
    endtask
    task automatic check_reset(string name);
        chk({name, "_anode"}, {4'h0, anode}, 8'h0F);
        chk({name, "_segs"}, {1'b0, segs}, 8'h7F);
        chk({name, "_fd"}, {7'h0, frame_done}, 8'h00);
    endtask
    // Run through the first frame that starts at or after the latest load, checking each digit slot.
    task automatic show_frame(string name, logic [3:0][6:0] exp);
        int f, t, s;
        f = (cyc + FR - 1) / FR;
        while (cyc < FR * f + FR) begin
            step(1'b0, value, digit_en);
            t = cyc - 1;
            if (t >= FR * f && t % R == G) begin
                s = (t % FR) / R;
                chk({name, "_segs"}, {1'b0, segs}, {1'b0, exp[s]});
                chk({name, "_anode"}, {4'h0, anode}, {4'h0, ~(4'b0001 << s)});
            end
        end
    endtask
    initial begin
        int n;
        tbl[0] = '{16'h1A2F, 4'hF, {7'h79, 7'h08, 7'h24, 7'h0E}};
        tbl[1] = '{16'h8888, 4'b0101, {7'h7F, 7'h00, 7'h7F, 7'h00}};
        tbl[2] = '{16'h7E5B, 4'hF, {7'h78, 7'h06, 7'h12, 7'h03}};
`ifdef LEADING_ZERO_BLANK_EN
        tbl[3] = '{16'h0030, 4'hF, {7'h7F, 7'h7F, 7'h30, 7'h40}};
        tbl[4] = '{16'h0000, 4'hF, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        tbl[5] = '{16'h0C09, 4'hF, {7'h7F, 7'h46, 7'h40, 7'h10}};
`else
        tbl[3] = '{16'h0030, 4'hF, {7'h40, 7'h40, 7'h30, 7'h40}};
        tbl[4] = '{16'h0000, 4'hF, {7'h40, 7'h40, 7'h40, 7'h40}};
        tbl[5] = '{16'h0C09, 4'hF, {7'h40, 7'h46, 7'h40, 7'h10}};
`endif
        repeat (3) begin
            @(negedge clk);
            check_reset("reset");
        end
        rst_n = 1'b1;
        cyc = 0;
        step(1'b0, '0, '0);
        step(1'b0, '0, '0);
        chk("guard_after_release", {4'h0, anode}, 8'h0F);
        step(1'b0, '0, '0);
        chk("first_anode", {4'h0, anode}, 8'h0E);
        foreach (tbl[i]) begin
            step(1'b1, tbl[i].v, tbl[i].e);
            show_frame($sformatf("table%0d", i), tbl[i].s);
        end
        while (cyc % FR != 18) step(1'b0, '0, '0);
        step(1'b1, 16'h1234, 4'hF);
        while (cyc % FR != 26) step(1'b0, '0, '0);
        step(1'b1, 16'h5678, 4'hF);
        show_frame("double_buffer", {7'h12, 7'h02, 7'h78, 7'h00});
        n = 0;
        while (frame_done !== 1'b1 && n < 2 * FR) begin
            step(1'b0, '0, '0);
            n++;
        end
        chk("frame_done_seen", {7'h0, frame_done}, 8'h01);
        step(1'b1, 16'h00C0, 4'hF);
`ifdef LEADING_ZERO_BLANK_EN
        show_frame("collision", {7'h7F, 7'h7F, 7'h46, 7'h40});
`else
        show_frame("collision", {7'h40, 7'h40, 7'h46, 7'h40});
`endif
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                while (cyc % FR != 13) step(1'b0, '0, '0);
                step(1'b1, 16'hBEEF, 4'hF);
                #2 rst_n = 1'b0;
                #1 check_reset("async_reset");
                @(negedge clk);
                check_reset("held_reset");
                rst_n = 1'b1;
                cyc = 0;
                q.delete();
            end
            step($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
